// File: rtl/fifo_buffer_if.sv
// Strobe/status bundle between control_fsm (master) and fifo_buffer (slave).
// wen/ren are per-cycle requests; accepted when the registered full/empty allow it.
interface fifo_buffer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  wen;
  logic                  ren;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wen, ren, data_in,
    input  data_out, full, empty, count, overflow, underflow
  );

  modport slave (
    input  wen, ren, data_in,
    output data_out, full, empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_buffer.sv
// Synchronous FIFO: register-array storage, wrapping pointers, registered
// full/empty/count status and one-cycle overflow/underflow pulses.
module fifo_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input logic          clock,
  input logic          reset,
  fifo_buffer_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic wr_accept;
  logic rd_accept;

  // A write into a full FIFO is allowed when a read frees the oldest slot on the same edge.
  assign wr_accept = bus.wen && (!full_q || bus.ren);
  assign rd_accept = bus.ren && !empty_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    overflow_d  = bus.wen && full_q && !bus.ren;
    underflow_d = bus.ren && empty_q;

    if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_accept) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      data_out_d = mem_q[rd_ptr_q];
    end

    if (wr_accept && !rd_accept)      count_d = count_q + CNT_ONE;
    else if (rd_accept && !wr_accept) count_d = count_q - CNT_ONE;

    full_d  = (count_d == FULL_COUNT);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage carries no reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clock) begin
    if (wr_accept) mem_q[wr_ptr_q] <= bus.data_in;
  end

  assign bus.data_out  = data_out_q;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_fifo_buffer.sv
// Directed testbench for fifo_buffer: fill/drain ordering, overflow/underflow
// pulses, simultaneous read/write at the boundaries, wrap-around and async reset.
module tb_fifo_buffer;
  logic clock;
  logic reset;
  int   checks;
  int   errors;
  logic [7:0] exp_q[$];

  fifo_buffer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

  fifo_buffer #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Driver: apply strobes for one edge, then sample 1 time unit after it.
  task automatic do_cycle(input logic w, input logic r, input logic [7:0] d);
    bus.wen     = w;
    bus.ren     = r;
    bus.data_in = d;
    @(posedge clock);
    #1;
    bus.wen     = 1'b0;
    bus.ren     = 1'b0;
  endtask

  task automatic test_reset();
    bus.wen = 1'b0; bus.ren = 1'b0; bus.data_in = 8'h00;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b0, 1'b0, 8'h00);
      checks++;
      if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.count !== 4'd0) begin
        errors++;
        $display("FAIL reset_status[%0d]: empty=%b full=%b count=%0d, expected 1 0 0",
                 i, bus.empty, bus.full, bus.count);
      end
      checks++;
      if (bus.data_out !== 8'h00 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: data_out=%h ovf=%b udf=%b, expected 00 0 0",
                 i, bus.data_out, bus.overflow, bus.underflow);
      end
    end
  endtask

  task automatic test_fill(input logic [7:0] base);
    for (int i = 0; i < 8; i++) begin
      do_cycle(1'b1, 1'b0, base + 8'(i));
      checks++;
      if (bus.count !== 4'(i + 1) || bus.full !== (i == 7) || bus.empty !== 1'b0) begin
        errors++;
        $display("FAIL fill[%0d]: count=%0d full=%b empty=%b, expected %0d %b 0",
                 i, bus.count, bus.full, bus.empty, i + 1, (i == 7));
      end
    end
  endtask

  task automatic test_drain(input logic [7:0] base);
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) exp_q.push_back(base + 8'(i));
    for (int i = 0; i < 8; i++) begin
      do_cycle(1'b0, 1'b1, 8'h00);
      exp = exp_q.pop_front();
      checks++;
      if (bus.data_out !== exp || bus.count !== 4'(7 - i) || bus.empty !== (i == 7)) begin
        errors++;
        $display("FAIL drain[%0d]: data_out=%h count=%0d empty=%b, expected %h %0d %b",
                 i, bus.data_out, bus.count, bus.empty, exp, 7 - i, (i == 7));
      end
    end
    do_cycle(1'b0, 1'b0, 8'h00);
    checks++;
    if (bus.data_out !== base + 8'd7) begin
      errors++;
      $display("FAIL drain_hold: data_out=%h expected %h", bus.data_out, base + 8'd7);
    end
  endtask

  task automatic test_overflow();
    test_fill(8'h11);
    do_cycle(1'b1, 1'b0, 8'h99);
    checks++;
    if (bus.overflow !== 1'b1 || bus.count !== 4'd8 || bus.full !== 1'b1) begin
      errors++;
      $display("FAIL overflow_pulse: ovf=%b count=%0d full=%b, expected 1 8 1",
               bus.overflow, bus.count, bus.full);
    end
    do_cycle(1'b0, 1'b0, 8'h00);
    checks++;
    if (bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: ovf=%b expected 0", bus.overflow);
    end
    test_drain(8'h11);
  endtask

  task automatic test_underflow();
    do_cycle(1'b0, 1'b1, 8'h00);
    checks++;
    if (bus.underflow !== 1'b1 || bus.data_out !== 8'h18 || bus.count !== 4'd0) begin
      errors++;
      $display("FAIL underflow_pulse: udf=%b data_out=%h count=%0d, expected 1 18 0",
               bus.underflow, bus.data_out, bus.count);
    end
    do_cycle(1'b0, 1'b0, 8'h00);
    checks++;
    if (bus.underflow !== 1'b0) begin
      errors++;
      $display("FAIL underflow_clear: udf=%b expected 0", bus.underflow);
    end
    do_cycle(1'b1, 1'b1, 8'h42);
    checks++;
    if (bus.count !== 4'd1 || bus.underflow !== 1'b1 || bus.data_out !== 8'h18 ||
        bus.empty !== 1'b0) begin
      errors++;
      $display("FAIL empty_rw: count=%0d udf=%b data_out=%h empty=%b, expected 1 1 18 0",
               bus.count, bus.underflow, bus.data_out, bus.empty);
    end
    do_cycle(1'b0, 1'b1, 8'h00);
    checks++;
    if (bus.data_out !== 8'h42 || bus.empty !== 1'b1 || bus.underflow !== 1'b0) begin
      errors++;
      $display("FAIL empty_rw_read: data_out=%h empty=%b udf=%b, expected 42 1 0",
               bus.data_out, bus.empty, bus.underflow);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0, 8'h01 + 8'(i));
    for (int i = 0; i < 5; i++) begin
      do_cycle(1'b0, 1'b1, 8'h00);
      checks++;
      if (bus.data_out !== 8'h01 + 8'(i)) begin
        errors++;
        $display("FAIL wrap_pre[%0d]: data_out=%h expected %h", i, bus.data_out, 8'h01 + 8'(i));
      end
    end
    test_fill(8'hA0);
    do_cycle(1'b1, 1'b1, 8'hB0);
    checks++;
    if (bus.data_out !== 8'hA0 || bus.count !== 4'd8 || bus.full !== 1'b1 ||
        bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_rw: data_out=%h count=%0d full=%b ovf=%b, expected a0 8 1 0",
               bus.data_out, bus.count, bus.full, bus.overflow);
    end
    do_cycle(1'b0, 1'b1, 8'h00);
    checks++;
    if (bus.data_out !== 8'hA1 || bus.count !== 4'd7) begin
      errors++;
      $display("FAIL full_rw_next: data_out=%h count=%0d, expected a1 7",
               bus.data_out, bus.count);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.empty !== 1'b1 || bus.count !== 4'd0 || bus.data_out !== 8'h00 ||
        bus.full !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: empty=%b count=%0d data_out=%h full=%b, expected 1 0 00 0",
               bus.empty, bus.count, bus.data_out, bus.full);
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    do_cycle(1'b1, 1'b0, 8'h5A);
    do_cycle(1'b0, 1'b1, 8'h00);
    checks++;
    if (bus.data_out !== 8'h5A || bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_rw: data_out=%h empty=%b, expected 5a 1",
               bus.data_out, bus.empty);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fill(8'h11);
    test_drain(8'h11);
    test_overflow();
    test_underflow();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
